stage_e: RTL and testbench

STAGE_E -- requirements
Module: stage_e

---
 rtl/stage_e.sv | 156 +++++++++++++++
 tb/tb_stage_e.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_e.sv
// Execute stage of a small MIPS-subset pipeline: decode of the ALU controls,
// the ALU, the E-stage write-back select, and the E/M pipeline register.
module stage_e (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrE,
    input  logic [31:0] ForwardE1,
    input  logic [31:0] ForwardE2,
    input  logic [31:0] Imm32E,
    input  logic [4:0]  A3E,
    input  logic [31:0] WDE,
    output logic [4:0]  A3EM,
    output logic [31:0] WDEM,
    output logic [31:0] InstrM,
    output logic [31:0] ALUOutM,
    output logic [31:0] RD2M,
    output logic [4:0]  A3M,
    output logic [31:0] WDM
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_LUI  = 4'd4;

    // Destination source: 0 = carried A3E/WDE, 1 = rd/ALU, 2 = rt/ALU.
    localparam logic [1:0] GEN_PASS = 2'd0;
    localparam logic [1:0] GEN_RD   = 2'd1;
    localparam logic [1:0] GEN_RT   = 2'd2;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  gen_e;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    logic [31:0] instr_q,  instr_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rd2_q,    rd2_d;
    logic [4:0]  a3_q,     a3_d;
    logic [31:0] wd_q,     wd_d;

    assign op    = InstrE[31:26];
    assign funct = InstrE[5:0];

    // Anything not recognised (nop, branches, jumps, jr) falls through as an
    // ADD on the register operands with the carried destination.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        gen_e   = GEN_PASS;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    gen_e = GEN_RD;
                end else if (funct == FN_SUBU) begin
                    alu_op = ALU_SUB;
                    gen_e  = GEN_RD;
                end
            end
            OP_ORI: begin
                alu_op  = ALU_OR;
                alu_src = 1'b1;
                gen_e   = GEN_RT;
            end
            OP_LUI: begin
                alu_op  = ALU_LUI;
                alu_src = 1'b1;
                gen_e   = GEN_RT;
            end
            OP_LW, OP_SW: begin
                alu_src = 1'b1;
            end
            default: begin
                alu_op = ALU_ADD;
            end
        endcase
    end

    assign alu_b = alu_src ? Imm32E : ForwardE2;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = ForwardE1 + alu_b;
            ALU_SUB: alu_result = ForwardE1 - alu_b;
            ALU_OR:  alu_result = ForwardE1 | alu_b;
            ALU_AND: alu_result = ForwardE1 & alu_b;
            ALU_LUI: alu_result = {alu_b[15:0], 16'h0000};
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        A3EM = A3E;
        WDEM = WDE;
        case (gen_e)
            GEN_RD: begin
                A3EM = InstrE[15:11];
                WDEM = alu_result;
            end
            GEN_RT: begin
                A3EM = InstrE[20:16];
                WDEM = alu_result;
            end
            default: begin
                A3EM = A3E;
                WDEM = WDE;
            end
        endcase
    end

    always_comb begin
        instr_d  = InstrE;
        aluout_d = alu_result;
        rd2_d    = ForwardE2;
        a3_d     = A3EM;
        wd_d     = WDEM;
    end

    // No enable: the E/M register loads every cycle; reset leaves a nop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= 32'd0;
            aluout_q <= 32'd0;
            rd2_q    <= 32'd0;
            a3_q     <= 5'd0;
            wd_q     <= 32'd0;
        end else begin
            instr_q  <= instr_d;
            aluout_q <= aluout_d;
            rd2_q    <= rd2_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
        end
    end

    assign InstrM  = instr_q;
    assign ALUOutM = aluout_q;
    assign RD2M    = rd2_q;
    assign A3M     = a3_q;
    assign WDM     = wd_q;

endmodule

// File: tb/tb_stage_e.sv
// Bench for stage_e: directed scenarios with literal expectations, then
// random instruction streams checked every cycle against an instruction-level model.
module tb_stage_e;

    logic        clk;
    logic        reset;
    logic [31:0] InstrE, ForwardE1, ForwardE2, Imm32E, WDE;
    logic [4:0]  A3E;
    logic [4:0]  A3EM, A3M;
    logic [31:0] WDEM, InstrM, ALUOutM, RD2M, WDM;

    int checks = 0;
    int errors = 0;
    logic run_cmp = 1'b0;

    stage_e dut (
        .clk       (clk),
        .reset     (reset),
        .InstrE    (InstrE),
        .ForwardE1 (ForwardE1),
        .ForwardE2 (ForwardE2),
        .Imm32E    (Imm32E),
        .A3E       (A3E),
        .WDE       (WDE),
        .A3EM      (A3EM),
        .WDEM      (WDEM),
        .InstrM    (InstrM),
        .ALUOutM   (ALUOutM),
        .RD2M      (RD2M),
        .A3M       (A3M),
        .WDM       (WDM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] alu;
    } res_t;

    // What the E stage must produce for one instruction, by instruction name.
    function automatic res_t model(input logic [31:0] instr, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm,
                                   input logic [4:0] a3e, input logic [31:0] wde);
        res_t r;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        r.a3  = a3e;
        r.wd  = wde;
        r.alu = a + b;
        if (op == 6'h00 && fn == 6'h21) begin
            r.alu = a + b;
            r.a3  = instr[15:11];
            r.wd  = r.alu;
        end else if (op == 6'h00 && fn == 6'h23) begin
            r.alu = a - b;
            r.a3  = instr[15:11];
            r.wd  = r.alu;
        end else if (op == 6'h0D) begin
            r.alu = a | imm;
            r.a3  = instr[20:16];
            r.wd  = r.alu;
        end else if (op == 6'h0F) begin
            r.alu = imm * 32'h0001_0000;
            r.a3  = instr[20:16];
            r.wd  = r.alu;
        end else if (op == 6'h23 || op == 6'h2B) begin
            r.alu = a + imm;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected E/M contents, tracked at the instruction level.
    logic [31:0] exp_instr, exp_alu, exp_rd2, exp_wd;
    logic [4:0]  exp_a3;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_instr <= 32'd0;
            exp_alu   <= 32'd0;
            exp_rd2   <= 32'd0;
            exp_a3    <= 5'd0;
            exp_wd    <= 32'd0;
        end else begin
            res_t r;
            r = model(InstrE, ForwardE1, ForwardE2, Imm32E, A3E, WDE);
            exp_instr <= InstrE;
            exp_alu   <= r.alu;
            exp_rd2   <= ForwardE2;
            exp_a3    <= r.a3;
            exp_wd    <= r.wd;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            res_t r;
            r = model(InstrE, ForwardE1, ForwardE2, Imm32E, A3E, WDE);
            chk("cmp_A3EM",    {27'd0, A3EM}, {27'd0, r.a3});
            chk("cmp_WDEM",    WDEM,    r.wd);
            chk("cmp_InstrM",  InstrM,  exp_instr);
            chk("cmp_ALUOutM", ALUOutM, exp_alu);
            chk("cmp_RD2M",    RD2M,    exp_rd2);
            chk("cmp_A3M",     {27'd0, A3M}, {27'd0, exp_a3});
            chk("cmp_WDM",     WDM,     exp_wd);
        end
    end

    task automatic set_in(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [4:0] a3e, input logic [31:0] wde);
        InstrE    = instr;
        ForwardE1 = a;
        ForwardE2 = b;
        Imm32E    = imm;
        A3E       = a3e;
        WDE       = wde;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, "_InstrM"},  InstrM,  32'd0);
        chk({tag, "_ALUOutM"}, ALUOutM, 32'd0);
        chk({tag, "_RD2M"},    RD2M,    32'd0);
        chk({tag, "_A3M"},     {27'd0, A3M}, 32'd0);
        chk({tag, "_WDM"},     WDM,     32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [7];
        logic [5:0]  fns [3];
        logic [31:0] body;
        int k;
        ops = '{6'h0D, 6'h23, 6'h2B, 6'h0F, 6'h04, 6'h02, 6'h03};
        fns = '{6'h21, 6'h23, 6'h08};
        body = $urandom;
        k = $urandom_range(0, 11);
        if (k < 3)       return {6'h00, body[25:6], fns[k]};
        else if (k < 10) return {ops[k-3], body[25:0]};
        else if (k == 10) return 32'd0;
        else             return $urandom;
    endfunction

    initial begin
        reset = 1'b1;
        set_in(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        #1;
        chk_m_zero("reset_init");
        #6;
        reset = 1'b0;
        run_cmp = 1'b1;

        // addu $3,$1,$2
        @(posedge clk); #1;
        set_in(32'h0022_1821, 32'd5, 32'd7, 32'd0, 5'd0, 32'd0);
        #1;
        chk("addu_WDEM", WDEM, 32'd12);
        chk("addu_A3EM", {27'd0, A3EM}, 32'd3);
        step();
        chk("addu_ALUOutM", ALUOutM, 32'd12);
        chk("addu_A3M", {27'd0, A3M}, 32'd3);
        chk("addu_RD2M", RD2M, 32'd7);
        $display("txn addu: ALUOutM=0x%08h A3M=%0d", ALUOutM, A3M);

        // subu $4,$0,$0 with 0-1
        set_in(32'h0000_2023, 32'd0, 32'd1, 32'd0, 5'd0, 32'd0);
        step();
        chk("subu_ALUOutM", ALUOutM, 32'hFFFF_FFFF);
        chk("subu_A3M", {27'd0, A3M}, 32'd4);
        $display("txn subu: ALUOutM=0x%08h A3M=%0d", ALUOutM, A3M);

        // addu wrap-around
        set_in(32'h0022_1821, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0);
        step();
        chk("wrap_ALUOutM", ALUOutM, 32'd0);
        $display("txn addu-wrap: ALUOutM=0x%08h", ALUOutM);

        // ori $5,$0,0x1234
        set_in(32'h3405_1234, 32'hFFFF_0000, 32'h1111_1111, 32'h0000_1234, 5'd0, 32'd0);
        step();
        chk("ori_ALUOutM", ALUOutM, 32'hFFFF_1234);
        chk("ori_A3M", {27'd0, A3M}, 32'd5);
        chk("ori_WDM", WDM, 32'hFFFF_1234);
        chk("ori_RD2M", RD2M, 32'h1111_1111);
        $display("txn ori: ALUOutM=0x%08h A3M=%0d WDM=0x%08h", ALUOutM, A3M, WDM);

        // lui $6,0xABCD
        set_in(32'h3C06_ABCD, 32'h1234_5678, 32'd0, 32'h0000_ABCD, 5'd0, 32'd0);
        step();
        chk("lui_ALUOutM", ALUOutM, 32'hABCD_0000);
        chk("lui_A3M", {27'd0, A3M}, 32'd6);
        $display("txn lui: ALUOutM=0x%08h A3M=%0d", ALUOutM, A3M);

        // sw
        set_in(32'hAC00_0008, 32'h0000_0100, 32'h0000_DEAD, 32'd8, 5'd0, 32'd0);
        step();
        chk("sw_ALUOutM", ALUOutM, 32'h0000_0108);
        chk("sw_RD2M", RD2M, 32'h0000_DEAD);
        $display("txn sw: ALUOutM=0x%08h RD2M=0x%08h", ALUOutM, RD2M);

        // lw keeps the carried destination
        set_in(32'h8C45_0010, 32'h0000_0200, 32'd3, 32'h10, 5'd9, 32'h0000_0777);
        step();
        chk("lw_ALUOutM", ALUOutM, 32'h0000_0210);
        chk("lw_A3M", {27'd0, A3M}, 32'd9);
        chk("lw_WDM", WDM, 32'h0000_0777);
        $display("txn lw: ALUOutM=0x%08h A3M=%0d", ALUOutM, A3M);

        // jal
        set_in(32'h0C00_0C02, 32'd1, 32'd2, 32'd0, 5'd31, 32'h0000_3008);
        step();
        chk("jal_A3M", {27'd0, A3M}, 32'd31);
        chk("jal_WDM", WDM, 32'h0000_3008);
        $display("txn jal: A3M=%0d WDM=0x%08h", A3M, WDM);

        // Asynchronous reset pulse between edges while data is held.
        set_in(32'h0022_1821, 32'd20, 32'd22, 32'd0, 5'd0, 32'd0);
        step();
        chk("prereset_ALUOutM", ALUOutM, 32'd42);
        #1 reset = 1'b1;
        #1;
        chk_m_zero("async_reset");
        chk("reset_WDEM", WDEM, 32'd42);
        chk("reset_A3EM", {27'd0, A3EM}, 32'd3);
        #4 reset = 1'b0;
        #1;
        chk_m_zero("held_after_release");
        step();
        chk("reload_ALUOutM", ALUOutM, 32'd42);
        chk("reload_InstrM", InstrM, 32'h0022_1821);
        $display("txn reset-pulse: reload ALUOutM=0x%08h", ALUOutM);

        // Random stream with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            set_in(rand_instr(), $urandom, $urandom,
                   ($urandom_range(0, 1) == 1) ? {16'hFFFF, 16'($urandom)} : {16'h0000, 16'($urandom)},
                   5'($urandom), $urandom);
            if ($urandom_range(0, 19) == 0) begin
                #1 reset = 1'b1;
                #1;
                chk_m_zero("rand_reset");
                #4 reset = 1'b0;
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
